// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and byte type used by rx, tx and buffering.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] uart_byte_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of receiver handshake, stream output and status/control for uart_rx_fifo.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic             rx_ready;
  uart_byte_t       rx_data;
  logic             rx_ready_clr;
  uart_byte_t       m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             overflow;
  logic             ovf_clr;
  logic             flush;

  // Buffer side
  modport slave (
    input  rx_ready, rx_data, m_ready, ovf_clr, flush,
    output rx_ready_clr, m_data, m_valid, count, full, overflow
  );

  // Receiver / host side
  modport master (
    output rx_ready, rx_data, m_ready, ovf_clr, flush,
    input  rx_ready_clr, m_data, m_valid, count, full, overflow
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO: storage, wrapping pointers, occupancy.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CNT_W = fifo_cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  uart_byte_t       wr_data_i,
  output uart_byte_t       rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  uart_byte_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer/count values; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q] <= wr_data_i;
  end

  // When full and popping, wr_ptr equals rd_ptr: the head is read combinationally
  // this cycle and overwritten at the edge, which is exactly the intended behaviour.
  assign rd_data_o = mem[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures receiver bytes, acknowledges them, queues them FWFT.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int CNT_W = fifo_cnt_w(DEPTH);

  logic             rx_ready_clr_q, rx_ready_clr_d;
  logic             overflow_q, overflow_d;
  logic             cap, push, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  uart_byte_t       fifo_head;

  // Capture once per receiver byte: the pending clear masks the still-high ready.
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  always_comb begin
    cap            = bus.rx_ready && !rx_ready_clr_q;
    pop            = !fifo_empty && bus.m_ready && !bus.flush;
    push           = cap && (!fifo_full || pop) && !bus.flush;
    drop           = cap && fifo_full && !pop && !bus.flush;
    rx_ready_clr_d = cap;
    overflow_d     = overflow_q;
    if (drop)             overflow_d = 1'b1;
    else if (bus.ovf_clr) overflow_d = 1'b0;
  end

  // Handshake pulse and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready_clr_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      rx_ready_clr_q <= rx_ready_clr_d;
      overflow_q     <= overflow_d;
    end
  end

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .flush_i   (bus.flush),
    .wr_data_i (bus.rx_data),
    .rd_data_o (fifo_head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign bus.rx_ready_clr = rx_ready_clr_q;
  assign bus.m_data       = fifo_head;
  assign bus.m_valid      = !fifo_empty;
  assign bus.count        = fifo_count;
  assign bus.full         = fifo_full;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus directed checks.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  byte unsigned mq[$];
  bit           m_ovf;
  bit           m_clr;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte is taken when the receiver shows ready and no ack is outstanding.
  always @(posedge clk or negedge rst) begin
    bit cap, pop, ovf_ev;
    int sz;
    if (!rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_clr = 1'b0;
    end else begin
      cap    = bus.rx_ready && !m_clr;
      sz     = mq.size();
      pop    = (sz > 0) && bus.m_ready && !bus.flush;
      ovf_ev = 1'b0;
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (cap) begin
          if (sz < DEPTH || pop) mq.push_back(bus.rx_data);
          else ovf_ev = 1'b1;
        end
      end
      if (ovf_ev)           m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
      m_clr = cap;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("clr",      int'(bus.rx_ready_clr), int'(m_clr));
    chk("m_valid",  int'(bus.m_valid),      int'(mq.size() != 0));
    chk("count",    int'(bus.count),        mq.size());
    chk("full",     int'(bus.full),         int'(mq.size() == DEPTH));
    chk("overflow", int'(bus.overflow),     int'(m_ovf));
    if (mq.size() != 0) chk("m_data", int'(bus.m_data), int'(mq[0]));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Receiver emulation: ready high for cycles N and N+1, low from N+2.
  task automatic send(input byte unsigned b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    tick(2);
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int hold, gap;
    bus.rx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.m_ready  = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.flush    = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);

    chk("rst_count", int'(bus.count), 0);
    chk("rst_valid", int'(bus.m_valid), 0);
    chk("rst_full",  int'(bus.full), 0);
    chk("rst_ovf",   int'(bus.overflow), 0);
    chk("rst_clr",   int'(bus.rx_ready_clr), 0);

    // Single byte, held for the full handshake window
    @(negedge clk);
    bus.rx_data  = 8'hA5;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    chk("single_clr",   int'(bus.rx_ready_clr), 1);
    chk("single_valid", int'(bus.m_valid), 1);
    chk("single_data",  int'(bus.m_data), 8'hA5);
    chk("single_count", int'(bus.count), 1);
    @(negedge clk);
    bus.rx_ready = 1'b0;
    chk("no_double_clr",   int'(bus.rx_ready_clr), 0);
    chk("no_double_count", int'(bus.count), 1);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("single_drain", int'(bus.count), 0);

    // Fill, overflow on the 17th byte, drain in order across the wrap
    for (int i = 0; i < 16; i++) send(byte'(i));
    chk("fill_full",  int'(bus.full), 1);
    chk("fill_count", int'(bus.count), 16);
    @(negedge clk);
    bus.rx_data  = 8'hFF;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    chk("drop_clr", int'(bus.rx_ready_clr), 1);
    chk("drop_ovf", int'(bus.overflow), 1);
    chk("drop_count", int'(bus.count), 16);
    @(negedge clk);
    bus.rx_ready = 1'b0;
    bus.m_ready  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", int'(bus.m_data), i);
      @(negedge clk);
    end
    bus.m_ready = 1'b0;
    chk("drain_empty", int'(bus.m_valid), 0);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;

    // Full with simultaneous pop: accepted, no overflow
    for (int i = 0; i < 16; i++) send(byte'(8'h10 + i));
    @(negedge clk);
    bus.rx_data  = 8'h55;
    bus.rx_ready = 1'b1;
    bus.m_ready  = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("fullpop_ovf",   int'(bus.overflow), 0);
    chk("fullpop_count", int'(bus.count), 16);
    @(negedge clk);
    bus.rx_ready = 1'b0;
    bus.m_ready  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("fullpop_order", int'(bus.m_data), 8'h11 + i);
      @(negedge clk);
    end
    chk("fullpop_last", int'(bus.m_data), 8'h55);
    @(negedge clk);
    bus.m_ready = 1'b0;

    // Flush keeps overflow; ovf_clr then clears it
    for (int i = 0; i < 17; i++) send(byte'(8'h80 + i));
    bus.m_ready = 1'b1;
    tick(11);
    bus.m_ready = 1'b0;
    chk("pre_flush_count", int'(bus.count), 5);
    chk("pre_flush_ovf",   int'(bus.overflow), 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_count", int'(bus.count), 0);
    chk("flush_valid", int'(bus.m_valid), 0);
    chk("flush_ovf",   int'(bus.overflow), 1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", int'(bus.overflow), 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) send(byte'(8'h20 + i));
    chk("pre_rst_count", int'(bus.count), 3);
    bus.rx_data  = 8'h77;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_count", int'(bus.count), 0);
    chk("async_valid", int'(bus.m_valid), 0);
    chk("async_full",  int'(bus.full), 0);
    chk("async_ovf",   int'(bus.overflow), 0);
    chk("async_clr",   int'(bus.rx_ready_clr), 0);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send(8'h3C);
    chk("post_rst_valid", int'(bus.m_valid), 1);
    chk("post_rst_data",  int'(bus.m_data), 8'h3C);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;

    // Randomised traffic, checked cycle by cycle against the model
    hold = 0;
    gap  = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      case ((c / 500) % 4)
        0:       bus.m_ready = ($urandom_range(0, 9) == 0);
        1:       bus.m_ready = ($urandom_range(0, 1) == 0);
        2:       bus.m_ready = ($urandom_range(0, 9) != 0);
        default: bus.m_ready = ($urandom_range(0, 3) == 0);
      endcase
      bus.flush   = ($urandom_range(0, 249) == 0);
      bus.ovf_clr = ($urandom_range(0, 59) == 0);
      if (hold > 0) begin
        hold--;
        if (hold == 0) bus.rx_ready = 1'b0;
      end else if (gap > 0) begin
        gap--;
      end else begin
        bus.rx_data  = 8'($urandom);
        bus.rx_ready = 1'b1;
        hold = 2;
        gap  = $urandom_range(0, 5);
      end
    end
    bus.rx_ready = 1'b0;
    bus.m_ready  = 1'b0;
    bus.flush    = 1'b0;
    bus.ovf_clr  = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each byte the receiver flags with `ready`, acknowledges it with a one-cycle `ready_clr` pulse, and stores it in a first-word-fall-through FIFO. The FIFO drains through a valid/ready stream port to the host logic. It also reports fill level and a sticky overflow flag.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `DATA_W`, 8: byte width; must match the receiver's `data_out`.
- `clk`  input  1  system clock, same as the receiver.
- `rst`  input  1  asynchronous, active-low reset.
- `rx_ready`  input  1  receiver's `ready` level; held high until cleared.
- `rx_data`  input  DATA_W  receiver's `data_out`; stable while `rx_ready`=1.
- `rx_ready_clr`  output  1  registered one-cycle pulse to the receiver's `ready_clr`.
- `m_data`  output  DATA_W  head-of-FIFO byte, valid when `m_valid`=1.
- `m_valid`  output  1  FIFO not empty.
- `m_ready`  input  1  consumer accepts `m_data` this cycle.
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  output  1  `count`==DEPTH.
- `overflow`  output  1  sticky: a byte was dropped because the FIFO was full.
- `ovf_clr`  input  1  synchronous clear of `overflow`.
- `flush`  input  1  synchronous empty of the FIFO.

## Operation
- Reset (`rst`=0, asynchronous): `rd_ptr`=`wr_ptr`=0, `count`=0, `m_valid`=0, `full`=0, `overflow`=0, `rx_ready_clr`=0. `m_data` is don't-care while empty. Storage contents are not reset.
- Capture condition: `cap = rx_ready && !rx_ready_clr`. The registered clear takes one more edge to drop `rx_ready`. The `!rx_ready_clr` guard prevents a byte from being captured twice.
- On `cap`, `rx_ready_clr`<=1 for exactly one cycle, always. This includes when the byte is dropped.
- Push: `cap && (!full || pop) && !flush` writes `rx_data` at `wr_ptr`, and `wr_ptr` increments with wrap modulo DEPTH.
- Pop: `m_valid && m_ready && !flush` increments `rd_ptr` with wrap.
- Count: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Full with simultaneous pop: the push is accepted, `count` stays DEPTH, and there is no overflow.
- Full without pop: the byte is discarded and `overflow`<=1.
- Flush: pointers and `count` go to 0. A byte captured in the same cycle is acknowledged and discarded without setting `overflow`. `overflow` is not affected by flush.
- `ovf_clr`: `overflow`<=0. If an overflow event occurs in the same cycle, set wins.
- `m_data` is a combinational read of `mem[rd_ptr]` (first-word fall-through).

## Timing
- Capture to output: a byte captured at the edge ending cycle N has `m_valid`=1 and correct `m_data` in cycle N+1. If the FIFO was not empty, it is queued behind older bytes.
- Receiver handshake sequence:
  - cycle N: `rx_ready`=1, capture;
  - cycle N+1: `rx_ready_clr`=1, `rx_ready` still 1, no capture;
  - cycle N+2: `rx_ready`=0.
- Back-to-back receiver bytes are ≥160 clock cycles apart. No rate limiting is required.
- `count`, `full` and `m_valid` are registered, or derived from registered state only. All three update on the same edge as the push or pop that changes them.
- Reset asserted mid-operation takes effect immediately. A byte present on `rx_ready` when reset is released is captured normally.

## Structure
- Package `uart_pkg` holds `DATA_W` and the byte typedef `uart_byte_t`, shared with the receiver and transmitter.
- Sub-module `uart_sync_fifo` holds the storage, pointers, count and full/empty logic, with push, pop and flush inputs. The top level holds the capture/clear handshake and the overflow flag.

## Test plan
- Single byte: `rx_data`=8'hA5, `rx_ready` raised, and the bench model drops it 2 cycles later.
  - `rx_ready_clr` pulses once in cycle N+1.
  - `m_valid`=1 with `m_data`=8'hA5 in cycle N+1, and `count`=1.
  - With `m_ready`=1, `count` returns to 0.
- No double capture: hold `rx_ready` high for the 2-cycle window. Exactly one push occurs, `count`=1.
- Fill and overflow: push 8'h00..8'h0F with `m_ready`=0.
  - `full`=1, `count`=16.
  - A 17th byte 8'hFF is acknowledged but dropped, and `overflow`=1.
  - Draining yields 8'h00..8'h0F in order, with wrap-around correct.
- Full plus simultaneous pop: with the FIFO full, capture 8'h55 in the same cycle as `m_ready`=1.
  - `overflow` stays 0, `count`=16.
  - 8'h55 emerges last.
- Flush and ovf_clr: with `overflow`=1 and `count`=5, assert `flush`.
  - `count`=0, `m_valid`=0, `overflow` still 1.
  - Asserting `ovf_clr` then gives `overflow`=0.
- Reset mid-operation: with `count`=3, drive `rst`=0 asynchronously between edges.
  - All outputs go to their reset values immediately.
  - After release, a new byte 8'h3C is captured and appears on `m_data`.
